mem_port_arbiter: RTL and testbench

Shares the single memory-controller port between the instruction-fetch cache (port 0) and the data cache (port 1). It accepts one request at a time, forwards it downstream, and routes the response back to its owner. Contention is resolved round-robin, and a timeout counter converts a missing response into an error response. It sits between the two cache subsystems and the memory controller.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter sharing one memory-controller port between icache (0) and dcache (1).
// One outstanding transaction; a missing response becomes an error response after TIMEOUT_CYCLES.
module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [1:0]            i_req_valid,
  input  logic [1:0]            i_req_rw,
  input  logic [2*XLEN-1:0]     i_req_addr,
  input  logic [2*XLEN-1:0]     i_req_wdata,
  input  logic [2*(XLEN/8)-1:0] i_req_wmask,
  output logic [1:0]            o_req_ready,
  output logic [1:0]            o_rsp_valid,
  output logic [XLEN-1:0]       o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_valid,
  output logic                  o_mem_rw,
  output logic [XLEN-1:0]       o_mem_addr,
  output logic [XLEN-1:0]       o_mem_wdata,
  output logic [XLEN/8-1:0]     o_mem_wmask,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [XLEN-1:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_grant;
  logic                r_owner;
  logic                r_rw;
  logic [XLEN-1:0]     r_addr;
  logic [XLEN-1:0]     r_wdata;
  logic [XLEN/8-1:0]   r_wmask;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_any_req;
  logic                w_winner;
  logic                w_timeout;
  logic                w_sel_rw;
  logic [XLEN-1:0]     w_sel_addr;
  logic [XLEN-1:0]     w_sel_wdata;
  logic [XLEN/8-1:0]   w_sel_wmask;

  // On a tie the port that did not win last time is granted.
  assign w_any_req   = |i_req_valid;
  assign w_winner    = (i_req_valid == 2'b11) ? ~r_last_grant : i_req_valid[1];
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign w_sel_rw    = w_winner ? i_req_rw[1] : i_req_rw[0];
  assign w_sel_addr  = w_winner ? i_req_addr[2*XLEN-1:XLEN] : i_req_addr[XLEN-1:0];
  assign w_sel_wdata = w_winner ? i_req_wdata[2*XLEN-1:XLEN] : i_req_wdata[XLEN-1:0];
  assign w_sel_wmask = w_winner ? i_req_wmask[2*(XLEN/8)-1:XLEN/8] : i_req_wmask[XLEN/8-1:0];

  assign o_mem_rw    = r_rw;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wmask = r_wmask;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (w_any_req) w_next_state = ISSUE;
      ISSUE:     if (i_mem_ready) w_next_state = WAIT_RESP;
      WAIT_RESP: if (i_mem_rvalid || w_timeout) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  // The accept strobe is combinational and masked while reset is held.
  always_comb begin
    o_req_ready = 2'b00;
    o_mem_valid = 1'b0;
    case (r_state)
      IDLE:    if (w_any_req && i_reset_n) o_req_ready[w_winner] = 1'b1;
      ISSUE:   o_mem_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_cnt        <= '0;
      o_rsp_valid  <= 2'b00;
      o_rsp_rdata  <= '0;
      o_rsp_err    <= 1'b0;
    end else begin
      o_rsp_valid <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_last_grant <= w_winner;
            r_owner      <= w_winner;
            r_rw         <= w_sel_rw;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_wmask      <= w_sel_wmask;
          end
        end
        ISSUE: begin
          if (i_mem_ready) r_cnt <= '0;
        end
        WAIT_RESP: begin
          // A response arriving in the timeout cycle still counts as a good response.
          if (i_mem_rvalid) begin
            o_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            o_rsp_rdata <= i_mem_rdata;
            o_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            o_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, round-robin contention, single read,
// backpressure, timeout with late response, and reset in the middle of a transaction.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic [1:0]      i_req_valid;
  logic [1:0]      i_req_rw;
  logic [63:0]     i_req_addr;
  logic [63:0]     i_req_wdata;
  logic [7:0]      i_req_wmask;
  logic [1:0]      o_req_ready;
  logic [1:0]      o_rsp_valid;
  logic [31:0]     o_rsp_rdata;
  logic            o_rsp_err;
  logic            o_mem_valid;
  logic            o_mem_rw;
  logic [31:0]     o_mem_addr;
  logic [31:0]     o_mem_wdata;
  logic [3:0]      o_mem_wmask;
  logic            i_mem_ready;
  logic            i_mem_rvalid;
  logic [31:0]     i_mem_rdata;

  int checks = 0;
  int passed = 0;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .i_req_rw(i_req_rw), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_wmask(i_req_wmask), .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_valid(o_mem_valid), .o_mem_rw(o_mem_rw), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask), .i_mem_ready(i_mem_ready),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rw,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] wmask, input logic memReady,
                               input logic memRvalid, input logic [31:0] memRdata);
    i_req_valid  = valid;
    i_req_rw     = rw;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    i_req_wmask  = wmask;
    i_mem_ready  = memReady;
    i_mem_rvalid = memRvalid;
    i_mem_rdata  = memRdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic nextCycle;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset_n = 1'b0;
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 32'h0);
    nextCycle;
    nextCycle;
    checkOutput("reset_mem_valid", 64'(o_mem_valid), 64'h0);
    checkOutput("reset_rsp_valid", 64'(o_rsp_valid), 64'h0);
    checkOutput("reset_rsp_rdata", 64'(o_rsp_rdata), 64'h0);
    checkOutput("reset_rsp_err", 64'(o_rsp_err), 64'h0);
    checkOutput("reset_mem_addr", 64'(o_mem_addr), 64'h0);
    applyStimulus(2'b11, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("reset_req_ready", 64'(o_req_ready), 64'h0);
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 32'h0);
    #3 i_reset_n = 1'b1;
    nextCycle;

    // Contention from reset: port 0 reads 0x200, port 1 writes 0xA5A5A5A5 to 0x300.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, 2'b10, {32'h300, 32'h200}, {32'hA5A5A5A5, 32'h0}, 8'hF0, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("rr_ready_%0d", k), 64'(o_req_ready), (k % 2 == 1) ? 64'h2 : 64'h1);
      if (k > 0) begin
        checkOutput($sformatf("rr_rsp_valid_%0d", k), 64'(o_rsp_valid), (k % 2 == 1) ? 64'h1 : 64'h2);
        checkOutput($sformatf("rr_rsp_rdata_%0d", k), 64'(o_rsp_rdata), 64'h1000 + 64'(k - 1));
      end
      nextCycle;
      checkOutput($sformatf("rr_mem_valid_%0d", k), 64'(o_mem_valid), 64'h1);
      checkOutput($sformatf("rr_mem_addr_%0d", k), 64'(o_mem_addr), (k % 2 == 1) ? 64'h300 : 64'h200);
      checkOutput($sformatf("rr_mem_rw_%0d", k), 64'(o_mem_rw), 64'(k % 2));
      checkOutput($sformatf("rr_issue_ready_%0d", k), 64'(o_req_ready), 64'h0);
      if (k % 2 == 1) begin
        checkOutput($sformatf("rr_wdata_%0d", k), 64'(o_mem_wdata), 64'hA5A5A5A5);
        checkOutput($sformatf("rr_wmask_%0d", k), 64'(o_mem_wmask), 64'hF);
      end
      nextCycle;
      applyStimulus(2'b11, 2'b10, {32'h300, 32'h200}, {32'hA5A5A5A5, 32'h0}, 8'hF0, 1'b1, 1'b1, 32'h1000 + 32'(k));
      checkOutput($sformatf("rr_wait_rsp_%0d", k), 64'(o_rsp_valid), 64'h0);
      nextCycle;
    end
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("rr_last_rsp_valid", 64'(o_rsp_valid), 64'h2);
    checkOutput("rr_last_rsp_rdata", 64'(o_rsp_rdata), 64'h1003);
    nextCycle;
    checkOutput("rr_pulse_end", 64'(o_rsp_valid), 64'h0);

    // Single read, minimum latency.
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h100}, 64'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("rd_ready_c0", 64'(o_req_ready), 64'h1);
    checkOutput("rd_mem_valid_c0", 64'(o_mem_valid), 64'h0);
    nextCycle;
    applyStimulus(2'b00, 2'b00, {32'h0, 32'h100}, 64'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("rd_mem_valid_c1", 64'(o_mem_valid), 64'h1);
    checkOutput("rd_mem_addr_c1", 64'(o_mem_addr), 64'h100);
    checkOutput("rd_mem_rw_c1", 64'(o_mem_rw), 64'h0);
    nextCycle;
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 1'b1, 32'hDEADBEEF);
    checkOutput("rd_mem_valid_c2", 64'(o_mem_valid), 64'h0);
    checkOutput("rd_rsp_valid_c2", 64'(o_rsp_valid), 64'h0);
    nextCycle;
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 1'b0, 32'h12345678);
    checkOutput("rd_rsp_valid_c3", 64'(o_rsp_valid), 64'h1);
    checkOutput("rd_rsp_rdata_c3", 64'(o_rsp_rdata), 64'hDEADBEEF);
    checkOutput("rd_rsp_err_c3", 64'(o_rsp_err), 64'h0);
    nextCycle;
    checkOutput("rd_rsp_valid_c4", 64'(o_rsp_valid), 64'h0);
    checkOutput("rd_rdata_hold_c4", 64'(o_rsp_rdata), 64'hDEADBEEF);

    // Backpressure: port 1 read of 0x400 stalls 5 cycles while port 0 waits with 0x500.
    applyStimulus(2'b10, 2'b00, {32'h400, 32'h0}, 64'h0, 8'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("bp_ready_accept", 64'(o_req_ready), 64'h2);
    nextCycle;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b01, 2'b00, {32'hBAD0BAD0, 32'h500}, 64'h0, 8'h0, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("bp_mem_valid_%0d", i), 64'(o_mem_valid), 64'h1);
      checkOutput($sformatf("bp_mem_addr_%0d", i), 64'(o_mem_addr), 64'h400);
      checkOutput($sformatf("bp_ready_%0d", i), 64'(o_req_ready), 64'h0);
      nextCycle;
    end
    applyStimulus(2'b01, 2'b00, {32'hBAD0BAD0, 32'h500}, 64'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_mem_addr_release", 64'(o_mem_addr), 64'h400);
    nextCycle;
    applyStimulus(2'b01, 2'b00, {32'hBAD0BAD0, 32'h500}, 64'h0, 8'h0, 1'b0, 1'b1, 32'h55);
    checkOutput("bp_wait_ready", 64'(o_req_ready), 64'h0);
    checkOutput("bp_wait_mem_valid", 64'(o_mem_valid), 64'h0);
    nextCycle;
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h500}, 64'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("bp_rsp_valid", 64'(o_rsp_valid), 64'h2);
    checkOutput("bp_rsp_rdata", 64'(o_rsp_rdata), 64'h55);
    checkOutput("bp_next_ready", 64'(o_req_ready), 64'h1);
    nextCycle;
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("to_mem_addr", 64'(o_mem_addr), 64'h500);
    nextCycle;

    // Timeout: accepted at the previous edge, no rvalid for 8 WAIT_RESP cycles.
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("to_quiet_%0d", i), 64'(o_rsp_valid), 64'h0);
      nextCycle;
    end
    checkOutput("to_rsp_valid", 64'(o_rsp_valid), 64'h1);
    checkOutput("to_rsp_err", 64'(o_rsp_err), 64'h1);
    checkOutput("to_rsp_rdata", 64'(o_rsp_rdata), 64'h0);
    nextCycle;
    checkOutput("to_pulse_end", 64'(o_rsp_valid), 64'h0);
    checkOutput("to_err_hold", 64'(o_rsp_err), 64'h1);
    nextCycle;
    nextCycle;
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 1'b1, 32'h77);
    nextCycle;
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("late_rsp_valid", 64'(o_rsp_valid), 64'h0);
    checkOutput("late_rsp_rdata", 64'(o_rsp_rdata), 64'h0);
    nextCycle;
    checkOutput("late_rsp_valid2", 64'(o_rsp_valid), 64'h0);

    // Reset while waiting for a response, then a tie must go to port 0.
    applyStimulus(2'b01, 2'b00, {32'h0, 32'h600}, 64'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("mr_ready", 64'(o_req_ready), 64'h1);
    nextCycle;
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b1, 1'b0, 32'h0);
    nextCycle;
    applyStimulus(2'b11, 2'b00, {32'h800, 32'h700}, 64'h0, 8'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("mr_wait_addr", 64'(o_mem_addr), 64'h600);
    #2 i_reset_n = 1'b0;
    #1;
    checkOutput("mr_rst_mem_addr", 64'(o_mem_addr), 64'h0);
    checkOutput("mr_rst_rsp_err", 64'(o_rsp_err), 64'h0);
    checkOutput("mr_rst_ready", 64'(o_req_ready), 64'h0);
    checkOutput("mr_rst_mem_valid", 64'(o_mem_valid), 64'h0);
    nextCycle;
    #2 i_reset_n = 1'b1;
    #1;
    checkOutput("mr_tie_ready", 64'(o_req_ready), 64'h1);
    nextCycle;
    applyStimulus(2'b00, 2'b00, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("mr_tie_addr", 64'(o_mem_addr), 64'h700);
    checkOutput("mr_no_rsp", 64'(o_rsp_valid), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
